// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive side of a multiplexed 4-digit, active-low 7-segment display bus.
// Each {anode, segment} pattern must stay unchanged for STABLE_CYCLES
// consecutive sampling edges before it is accepted. This filters out ghosting
// and transition glitches. An accepted pattern is decoded back to BCD and
// stored in the digit slot that its anode selects. When all four slots hold a
// value, the frame is published with a one-cycle valid strobe and per-digit
// error flags.
//
// Parameters
//   N              segment bus width, fixed at 7
//   STABLE_CYCLES  consecutive identical edges needed to accept (2..255)
//
// Ports
//   iclk      in   1   system clock, rising edge
//   irst      in   1   synchronous active-high reset
//   iSeg      in   N   segments, active-low, bit6=a ... bit0=g
//   iAn       in   4   digit anodes, active-low, iAn[0]=units digit
//   oBCD      out  16  last completed frame, [3:0]=digit0 ... [15:12]=digit3
//   oValid    out  1   one-cycle pulse when oBCD/oErr/oErrMask update
//   oErr      out  1   OR of oErrMask, held with the frame
//   oErrMask  out  4   bit k set if digit k held an undecodable pattern
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int N             = 7,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [N-1:0]  iSeg,
  input  logic [3:0]    iAn,
  output logic [15:0]   oBCD,
  output logic          oValid,
  output logic          oErr,
  output logic [3:0]    oErrMask
);

  // The counter is wide enough for the largest legal STABLE_CYCLES (255).
  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(STABLE_CYCLES - 1);

  // Maps a segment pattern to {invalid, bcd}. Any pattern that is not in the
  // table, including the all-off pattern, decodes to 4'hF with invalid set.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = {1'b0, 4'd0};
      7'b1001111: res = {1'b0, 4'd1};
      7'b0010010: res = {1'b0, 4'd2};
      7'b0000110: res = {1'b0, 4'd3};
      7'b1001100: res = {1'b0, 4'd4};
      7'b0100100: res = {1'b0, 4'd5};
      7'b0100000: res = {1'b0, 4'd6};
      7'b0001111: res = {1'b0, 4'd7};
      7'b0000000: res = {1'b0, 4'd8};
      7'b0000100: res = {1'b0, 4'd9};
      default:    res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N+3:0]       r_sample;    // {iAn, iSeg} from the previous edge
  logic [CNT_W-1:0]   r_cnt;       // consecutive identical edges, saturating
  logic [3:0]         r_mask;      // digits captured in the current frame
  logic [3:0]         r_digit [4]; // captured BCD per digit
  logic [3:0]         r_inv;       // per-digit invalid flag
  logic [15:0]        r_bcd;
  logic               r_valid;
  logic               r_err;
  logic [3:0]         r_err_mask;

  // ---------------------------------------------------------------------------
  // Combinational decision logic
  // ---------------------------------------------------------------------------
  logic [N+3:0]  w_in;
  logic          w_match;
  logic [3:0]    w_sel;
  logic          w_accept;
  logic [4:0]    w_dec;
  logic          w_frame_done;
  logic [3:0]    w_mask_next;

  assign w_in = {iAn, iSeg};

  // A zero count only occurs right after reset. The first edge after reset
  // therefore always starts a new run, even if the bus happens to match the
  // cleared sample register.
  assign w_match = (r_cnt != '0) && (w_in == r_sample);

  // Anode filter: only patterns with exactly one active anode select a digit.
  // Blank and multi-low patterns leave w_sel at zero and capture nothing.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel = 4'b0000;
    case (iAn)
      4'b1110: w_sel = 4'b0001;
      4'b1101: w_sel = 4'b0010;
      4'b1011: w_sel = 4'b0100;
      4'b0111: w_sel = 4'b1000;
      default: w_sel = 4'b0000;
    endcase
  end

  // Accept exactly on the STABLE_CYCLES-th identical edge. After that the
  // count saturates at C_STABLE, so a longer hold never accepts again.
  assign w_accept = w_match && (r_cnt == C_LAST) && (w_sel != 4'b0000);

  assign w_dec = f_decode(iSeg[6:0]);

  // The frame is published on the edge after the mask fills. That same edge
  // clears the mask, and any acceptance on it starts the next frame.
  assign w_frame_done = (r_mask == 4'b1111);
  assign w_mask_next  = (w_frame_done ? 4'b0000 : r_mask) |
                        (w_accept ? w_sel : 4'b0000);

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then sees pre-edge values. This is why the frame below publishes the old
  // digit registers, even when the same edge overwrites one of them.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_sample   <= '0;
      r_cnt      <= '0;
      r_mask     <= 4'b0000;
      r_inv      <= 4'b0000;
      r_bcd      <= 16'h0000;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_mask <= 4'b0000;
      // NOTE: the digit store is small and must read as zero after reset, so
      // it is cleared here instead of being left as an unreset memory.
      for (int k = 0; k < 4; k++) begin
        r_digit[k] <= 4'h0;
      end
    end else begin
      r_sample <= w_in;

      if (!w_match) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != C_STABLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Capture into the selected slot. A repeat capture before the frame
      // completes overwrites the slot, so the latest value wins.
      for (int k = 0; k < 4; k++) begin
        if (w_accept && w_sel[k]) begin
          r_digit[k] <= w_dec[3:0];
          r_inv[k]   <= w_dec[4];
        end
      end

      r_mask  <= w_mask_next;
      r_valid <= w_frame_done;

      if (w_frame_done) begin
        r_bcd      <= {r_digit[3], r_digit[2], r_digit[1], r_digit[0]};
        r_err_mask <= r_inv;
        r_err      <= |r_inv;
      end
    end
  end

  assign oBCD     = r_bcd;
  assign oValid   = r_valid;
  assign oErr     = r_err;
  assign oErrMask = r_err_mask;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder with STABLE_CYCLES = 4. Inputs change
// on the falling edge, and outputs are sampled on the falling edge. A
// background monitor counts oValid pulses, so the bench can check for
// missing or extra frames.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic        iclk;
  logic        irst;
  logic [6:0]  iSeg;
  logic [3:0]  iAn;
  logic [15:0] oBCD;
  logic        oValid;
  logic        oErr;
  logic [3:0]  oErrMask;

  int n_pass      = 0;
  int n_total     = 0;
  int valid_count = 0;

  seg7_scan_decoder #(
    .N             (7),
    .STABLE_CYCLES (4)
  ) dut (
    .iclk     (iclk),
    .irst     (irst),
    .iSeg     (iSeg),
    .iAn      (iAn),
    .oBCD     (oBCD),
    .oValid   (oValid),
    .oErr     (oErr),
    .oErrMask (oErrMask)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (oValid === 1'b1) valid_count++;
  end

  // Active-low segment patterns for the digits 0..9 (bit6=a ... bit0=g).
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0:       s = 7'b0000001;
      1:       s = 7'b1001111;
      2:       s = 7'b0010010;
      3:       s = 7'b0000110;
      4:       s = 7'b1001100;
      5:       s = 7'b0100100;
      6:       s = 7'b0100000;
      7:       s = 7'b0001111;
      8:       s = 7'b0000000;
      9:       s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] a;
    a = 4'b1111;
    a[k] = 1'b0;
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic hold_raw(input logic [3:0] an, input logic [6:0] seg,
                          input int n);
    iAn  = an;
    iSeg = seg;
    repeat (n) @(negedge iclk);
  endtask

  task automatic hold_digit(input int k, input int d, input int n);
    hold_raw(an_of(k), seg_of(d), n);
  endtask

  task automatic idle(input int n);
    hold_raw(4'b1111, 7'b1111111, n);
  endtask

  initial begin
    irst = 1'b1;
    iAn  = 4'b1111;
    iSeg = 7'b1111111;
    repeat (3) @(negedge iclk);

    // Reset state
    check("reset_bcd",   32'(oBCD),     32'h0000);
    check("reset_valid", 32'(oValid),   32'h0);
    check("reset_err",   32'(oErr),     32'h0);
    check("reset_mask",  32'(oErrMask), 32'h0);
    irst = 1'b0;
    idle(3);

    // Nominal frame 1,2,3,4 with an exact latency check on the last digit.
    // Edges E..E+3 accept, and E+4 publishes, so the 5th falling edge sees
    // oValid.
    valid_count = 0;
    hold_digit(0, 1, 8);
    hold_digit(1, 2, 8);
    hold_digit(2, 3, 8);
    hold_digit(3, 4, 4);
    check("lat_no_valid_early", 32'(oValid), 32'h0);
    @(negedge iclk);
    check("lat_valid",     32'(oValid),   32'h1);
    check("nom_bcd",       32'(oBCD),     32'h4321);
    check("nom_err",       32'(oErr),     32'h0);
    check("nom_errmask",   32'(oErrMask), 32'h0);
    @(negedge iclk);
    check("lat_valid_one_cycle", 32'(oValid), 32'h0);
    repeat (2) @(negedge iclk);
    idle(6);
    check("nom_pulse_count", 32'(valid_count), 32'd1);

    // Glitch rejection: a 3-cycle digit0 must not capture.
    valid_count = 0;
    hold_digit(0, 1, 3);
    hold_digit(1, 5, 8);
    hold_digit(2, 6, 8);
    hold_digit(3, 7, 8);
    idle(6);
    check("glitch_no_valid", 32'(valid_count), 32'd0);
    check("glitch_bcd_held", 32'(oBCD),        32'h4321);
    hold_digit(0, 1, 4);
    idle(6);
    check("glitch_recover_count", 32'(valid_count), 32'd1);
    check("glitch_recover_bcd",   32'(oBCD),        32'h7651);

    // Invalid pattern on digit2
    valid_count = 0;
    hold_digit(0, 1, 8);
    hold_digit(1, 2, 8);
    hold_raw(an_of(2), 7'b1111111, 8);
    hold_digit(3, 4, 8);
    idle(6);
    check("inv_count",   32'(valid_count), 32'd1);
    check("inv_bcd",     32'(oBCD),        32'h4F21);
    check("inv_errmask", 32'(oErrMask),    32'b0100);
    check("inv_err",     32'(oErr),        32'h1);

    // Anode filter: multi-low and blank anodes interleaved with a frame
    valid_count = 0;
    hold_raw(4'b0011, seg_of(8), 20);
    hold_digit(0, 9, 8);
    hold_raw(4'b1111, seg_of(0), 20);
    hold_digit(1, 8, 8);
    hold_raw(4'b0011, seg_of(1), 20);
    hold_digit(2, 7, 8);
    hold_raw(4'b1111, seg_of(3), 20);
    hold_digit(3, 6, 8);
    hold_raw(4'b0011, seg_of(2), 20);
    check("anode_count",   32'(valid_count), 32'd1);
    check("anode_bcd",     32'(oBCD),        32'h6789);
    check("anode_err",     32'(oErr),        32'h0);
    check("anode_errmask", 32'(oErrMask),    32'h0);

    // Reset mid-frame discards digits 0..2
    valid_count = 0;
    hold_digit(0, 3, 8);
    hold_digit(1, 3, 8);
    hold_digit(2, 3, 8);
    irst = 1'b1;
    iAn  = 4'b1111;
    iSeg = 7'b1111111;
    @(negedge iclk);
    irst = 1'b0;
    check("rst_mid_bcd", 32'(oBCD), 32'h0000);
    hold_digit(3, 8, 8);
    idle(6);
    check("rst_mid_no_valid", 32'(valid_count), 32'd0);
    hold_digit(0, 5, 8);
    hold_digit(1, 9, 8);
    hold_digit(2, 0, 8);
    idle(6);
    check("rst_mid_count", 32'(valid_count), 32'd1);
    check("rst_mid_bcd_new", 32'(oBCD),      32'h8095);

    // Back-to-back frames at minimum spacing. Frame B digit0 first appears on
    // frame A's completion edge and counts toward frame B.
    valid_count = 0;
    hold_digit(0, 0, 4);
    hold_digit(1, 1, 4);
    hold_digit(2, 2, 4);
    hold_digit(3, 3, 4);
    hold_digit(0, 9, 1);
    check("b2b_valid_a", 32'(oValid), 32'h1);
    check("b2b_bcd_a",   32'(oBCD),   32'h3210);
    repeat (3) @(negedge iclk);
    hold_digit(1, 4, 4);
    hold_digit(2, 5, 4);
    hold_digit(3, 6, 4);
    idle(6);
    check("b2b_count", 32'(valid_count), 32'd2);
    check("b2b_bcd_b", 32'(oBCD),        32'h6549);
    check("b2b_valid_idle", 32'(oValid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
